// File: rtl/regfile_pkg.sv
// Shared types, default widths and the write-port priority helper for regfile_mp.
package regfile_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned MAX_WRITE      = 4;

  typedef enum logic {CLEAR, READY} state_e;

  // Result of a priority search over write ports.
  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } wsel_t;

  // Highest-index set bit of match wins; hit=0 when no port matches.
  function automatic wsel_t prio_sel(input logic [MAX_WRITE-1:0] match);
    wsel_t s;
    s.hit = 1'b0;
    s.idx = 2'd0;
    for (int j = 0; j < MAX_WRITE; j++) begin
      if (match[j]) begin
        s.hit = 1'b1;
        s.idx = 2'(j);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: array value, optional same-cycle bypass, zero register, clear masking.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_WRITE  = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]           raddr_i,
  input  logic [DATA_WIDTH-1:0]           arr_val,
  input  logic [NUM_WRITE-1:0]            wen,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic                            init_busy,
  output logic [DATA_WIDTH-1:0]           rdata_o
);

  logic [MAX_WRITE-1:0]  match;
  wsel_t                 sel;
  logic [DATA_WIDTH-1:0] byp_val;

  // Pick the winning in-flight write for this address, then apply the overrides
  // in increasing precedence: bypass, zero register, clear in progress.
  always_comb begin
    match = '0;
    for (int j = 0; j < NUM_WRITE; j++)
      match[j] = wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr_i);
    sel     = prio_sel(match);
    byp_val = '0;
    for (int j = 0; j < NUM_WRITE; j++)
      if (sel.idx == 2'(j)) byp_val = wdata[j*DATA_WIDTH +: DATA_WIDTH];
    rdata_o = arr_val;
    if (BYPASS != 0 && sel.hit) rdata_o = byp_val;
    if (ZERO_REG != 0 && raddr_i == '0) rdata_o = '0;
    if (init_busy) rdata_o = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware clear sequence after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rdata,
  input  logic [NUM_WRITE-1:0]            wen,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
  output logic                            init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

  assign init_busy = (state_q == CLEAR);

  // Clear walks one entry per cycle; once ready, ports commit in ascending
  // index order so the highest-index port wins an address conflict.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_d     = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = '0;
      clr_ptr_d        = clr_ptr_q + 1'b1;
      // Completion is detected on the last entry, before the pointer wraps.
      if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = READY;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wen[j] && !(ZERO_REG != 0 && waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0))
          mem_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset only restarts the clear sequence; the array itself is zeroed by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      mem_q     <= mem_d;
    end
  end

  // One read port per requested read lane.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    regfile_read_port #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_WRITE (NUM_WRITE),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
    ) u_rp (
      .raddr_i  (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .arr_val  (mem_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .init_busy(init_busy),
      .rdata_o  (rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass+zero reg, and neither) driven in
// parallel and checked every cycle against a behavioural model.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NW-1:0]    wen = '0;
  logic [NW*AW-1:0] waddr = '0;
  logic [NW*DW-1:0] wdata = '0;
  logic [NR*DW-1:0] rdata_a, rdata_b;
  logic             busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW),
               .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .wen(wen),
    .waddr(waddr), .wdata(wdata), .init_busy(busy_a));

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW),
               .ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .wen(wen),
    .waddr(waddr), .wdata(wdata), .init_busy(busy_b));

  always #5 clk = ~clk;

  // Behavioural model: whole-array state plus a remaining-clear-cycles count.
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  int            busy_cnt = 0;
  bit            model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      busy_cnt = 32;
      for (int i = 0; i < 32; i++) begin
        mem_a[i] = '0;
        mem_b[i] = '0;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j]) begin
          if (waddr[j*AW +: AW] != 0) mem_a[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
          mem_b[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input bit zr, input int p);
    logic [AW-1:0] a;
    logic [DW-1:0] r;
    a = raddr[p*AW +: AW];
    if (busy_cnt > 0) return '0;
    if (zr && a == 0) return '0;
    r = zr ? mem_a[a] : mem_b[a];
    if (zr) begin  // only the bypassing instance forwards in-flight writes
      for (int j = 0; j < NW; j++)
        if (wen[j] && waddr[j*AW +: AW] == a) r = wdata[j*DW +: DW];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("busy_a", 32'(busy_a), 32'(busy_cnt > 0));
      chk("busy_b", 32'(busy_b), 32'(busy_cnt > 0));
      for (int p = 0; p < NR; p++) begin
        chk("rdata_a", rdata_a[p*DW +: DW], exp_rd(1'b1, p));
        chk("rdata_b", rdata_b[p*DW +: DW], exp_rd(1'b0, p));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[j]            = en;
    waddr[j*AW +: AW] = a;
    wdata[j*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  // Counts cycles until init_busy drops, bounded; drives junk writes meanwhile.
  task automatic wait_clear(input string nm);
    int cnt;
    cnt = 0;
    while (busy_a && cnt < 100) begin
      set_wr(0, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      set_wr(1, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      tick();
      cnt++;
    end
    wen = '0;
    chk(nm, 32'(cnt), 32'd32);
  endtask

  initial begin
    // Reset and clear
    rst = 1'b1;
    tick();
    chk("busy_after_rst", 32'(busy_a), 32'd1);
    chk("rdata_in_clear", rdata_a[DW-1:0], 32'h0);
    rst = 1'b0;
    wait_clear("clear_len");
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(31 - a));
      tick();
    end

    // Basic write / read
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    wen = '0;
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    #1;
    chk("basic_r5", rdata_a[DW-1:0], 32'hDEADBEEF);
    chk("basic_r6", rdata_a[2*DW-1:DW], 32'h0);

    // Same-address conflict: port 1 wins
    set_wr(0, 1'b1, 5'd7, 32'h11111111);
    set_wr(1, 1'b1, 5'd7, 32'h22222222);
    tick();
    wen = '0;
    set_rd(0, 5'd7);
    #1;
    chk("conflict_r7", rdata_b[DW-1:0], 32'h22222222);

    // Different addresses both commit
    set_wr(0, 1'b1, 5'd3, 32'hA);
    set_wr(1, 1'b1, 5'd4, 32'hB);
    tick();
    wen = '0;
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    #1;
    chk("dual_r3", rdata_a[DW-1:0], 32'hA);
    chk("dual_r4", rdata_a[2*DW-1:DW], 32'hB);

    // Bypass vs no bypass
    set_wr(0, 1'b1, 5'd9, 32'h12345678);
    set_rd(0, 5'd9);
    #1;
    chk("bypass_same", rdata_a[DW-1:0], 32'h12345678);
    chk("nobypass_old", rdata_b[DW-1:0], 32'h0);
    tick();
    wen = '0;
    #1;
    chk("nobypass_next", rdata_b[DW-1:0], 32'h12345678);

    // Zero register
    set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(0, 5'd0);
    #1;
    chk("zero_same", rdata_a[DW-1:0], 32'h0);
    tick();
    wen = '0;
    #1;
    chk("zero_after", rdata_a[DW-1:0], 32'h0);
    chk("nozero_r0", rdata_b[DW-1:0], 32'hFFFFFFFF);

    // Random traffic; half the time a narrow address window to provoke conflicts
    for (int c = 0; c < 400; c++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < NW; j++)
        set_wr(j, 1'($urandom_range(0, 1)),
               5'(narrow ? $urandom_range(0, 3) : $urandom_range(0, 31)), $urandom);
      for (int p = 0; p < NR; p++)
        set_rd(p, 5'(narrow ? $urandom_range(0, 3) : $urandom_range(0, 31)));
      tick();
    end

    // Reset mid-clear: restart must give a full clear and wipe old data
    set_wr(0, 1'b1, 5'd5, 32'hCAFEF00D);
    tick();
    wen = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("clear_len_restart");
    set_rd(0, 5'd5);
    #1;
    chk("r5_wiped", rdata_a[DW-1:0], 32'h0);
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(a));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
